player_hit_controller: RTL and testbench
========================================

Name: player_hit_controller

Overview:
- Downstream consumer of the player position controller's player_pos_x/y, player_w/h outputs.
- Each frame, tests the player hitbox against a serial stream of hazard rectangles from the attack/bullet generator and records the worst hit.
- At frame_tick, applies damage and heals to HP, then runs an invulnerability window with blink.
- Outputs feed the renderer (player_visible) and the game-state FSM (player_dead).

Parameters:
- MAX_HP, 20, HP ceiling and reset value (fits 8 bits).
- INVULN_FRAMES, 60, frame_ticks of invulnerability after a hit (fits 8 bits).
- BLINK_FRAMES, 4, frame_ticks per visibility toggle during invulnerability.
- HITBOX_SHRINK, 2, pixels trimmed from every side of the player box before the overlap test.

Ports:
- clk_player_control  in  1  player control clock
- reset  in  1  synchronous, active-high
- game_active  in  1  low = freeze: hazards and heals ignored, counters hold
- frame_tick  in  1  one-cycle pulse, end of frame evaluation window
- player_pos_x, player_pos_y  in  10 each  player top-left (pixels)
- player_w, player_h  in  10 each  player size (pixels)
- hazard_valid  in  1  hazard beat valid this cycle (no backpressure)
- hazard_x, hazard_y, hazard_w, hazard_h  in  10 each  hazard rectangle
- hazard_damage  in  4  damage of this hazard; 0 = harmless
- heal_valid  in  1  heal request pulse
- heal_amount  in  4  HP to add
- player_hp  out  8  current HP
- player_hit  out  1  one-cycle pulse when damage is applied
- player_invulnerable  out  1  high in INVULN
- player_visible  out  1  renderer enable
- player_dead  out  1  high in DEAD

Behaviour:
- Clock and reset: reset reset, synchronous, active-high; clock clk_player_control.
- Reset values: player_hp=MAX_HP, state=ALIVE, pending_damage=0, pending_heal=0, inv_cnt=0, blink_cnt=0, player_hit=0, player_invulnerable=0, player_visible=1, player_dead=0. Reset wins over every other input in the same cycle.
- Overlap test:
  - Player box = [x+S, x+w-S) by [y+S, y+h-S), where S = HITBOX_SHRINK.
  - Hit when px0 < hx+hw, hx < px1, py0 < hy+hh, hy < py1 (strict, edges touching = no hit).
  - Evaluate all sums in 11 bits, with no wrap.
  - If w <= 2S or h <= 2S, never hit.
- Accumulation, state ALIVE only, game_active=1:
  - On a valid overlapping beat: pending_damage <= max(pending_damage, hazard_damage). Take the maximum, not the sum.
  - On heal_valid: pending_heal <= min(pending_heal + heal_amount, MAX_HP). Heals also accumulate in INVULN.
- frame_tick with game_active=1:
  - new_hp = clamp(hp + pending_heal - pending_damage, 0, MAX_HP), computed signed in 10 bits.
  - pending_damage and pending_heal clear to 0.
  - A hazard or heal beat arriving in the same cycle as frame_tick belongs to the next frame.
- States:
  - ALIVE, with pending_damage>0 at tick: player_hit=1 on the next cycle (1-cycle latency, single cycle). If new_hp==0, go to DEAD. Otherwise go to INVULN with inv_cnt=INVULN_FRAMES and blink_cnt=0.
  - INVULN: hazards ignored. Each tick: inv_cnt--, blink_cnt wraps at BLINK_FRAMES and player_visible toggles on wrap. Tick with inv_cnt==1: go to ALIVE with player_visible=1.
  - DEAD: player_hp=0, player_visible=1. All hazards, heals and ticks are ignored. Only reset exits.
- game_active=0: no state, counter or HP change. Pending values hold. frame_tick is ignored.
- A damage value larger than hp saturates hp to 0 and goes to DEAD. Heals never exceed MAX_HP.

Decomposition:
- Shared package player_pkg:
  - State encoding ST_ALIVE/ST_INVULN/ST_DEAD (2 bits).
  - HP_W=8, DMG_W=4, POS_W=10.
- Sub-module player_hitbox_overlap: combinational rectangle test with the shrink parameter. The hit controller instantiates it once.

Test Plan:
- Player (320,240,30,30); hazard (340,250,10,10,dmg 3) valid, then frame_tick -> player_hit pulse 1 cycle later, hp 20->17, player_invulnerable=1.
- Hazard at x=348 (touches the shrunk edge 348) -> no hit. Hazard at x=347 -> hit.
- Two overlapping hazards, dmg 3 and 5, in one frame -> hp drops by 5 only. During the following 60 ticks, overlapping hazards leave hp unchanged. player_visible toggles every 4 ticks. Tick 60 returns to ALIVE with visible=1.
- hp=4, heal 3 plus dmg 5 in the same frame -> hp=2. hp=19 with heal 5 -> hp=20.
- hp=3 with dmg 7 -> hp=0, player_dead=1. Further heals and ticks are ignored. Reset -> hp=20, ALIVE.
- Hazard beat coincident with frame_tick -> applied at the next tick. game_active=0 through a tick -> no change. Reset asserted mid-INVULN -> all outputs return to reset values.

Source files
------------

// File: rtl/player_pkg.sv
// Shared types and widths for the player hit controller slice.
package player_pkg;
    localparam int HP_W  = 8;
    localparam int DMG_W = 4;
    localparam int POS_W = 10;

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_DEAD   = 2'd2
    } player_state_t;

    // Saturating HP add, never exceeds max_hp.
    function automatic logic [HP_W-1:0] sat_add_hp(input logic [HP_W-1:0] a,
                                                   input logic [HP_W-1:0] b,
                                                   input logic [HP_W-1:0] max_hp);
        logic [HP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_hp}) ? max_hp : s[HP_W-1:0];
    endfunction
endpackage

// File: rtl/player_hit_controller_if.sv
// Hazard and heal beat bus from the attack/bullet generator.
interface player_hit_controller_if;
    import player_pkg::*;

    // Valid-only beats: a beat is consumed on every clock edge where its valid
    // is high; there is no ready and the producer is never stalled.
    logic             hazard_valid;
    logic [POS_W-1:0] hazard_x;
    logic [POS_W-1:0] hazard_y;
    logic [POS_W-1:0] hazard_w;
    logic [POS_W-1:0] hazard_h;
    logic [DMG_W-1:0] hazard_damage;
    logic             heal_valid;
    logic [3:0]       heal_amount;

    modport master (
        output hazard_valid, hazard_x, hazard_y, hazard_w, hazard_h,
               hazard_damage, heal_valid, heal_amount
    );
    modport slave (
        input  hazard_valid, hazard_x, hazard_y, hazard_w, hazard_h,
               hazard_damage, heal_valid, heal_amount
    );
endinterface

// File: rtl/player_hitbox_overlap.sv
// Combinational strict-overlap test of a shrunk player box against a hazard box.
module player_hitbox_overlap
    import player_pkg::*;
#(
    parameter int SHRINK = 2
) (
    input  logic [POS_W-1:0] px,
    input  logic [POS_W-1:0] py,
    input  logic [POS_W-1:0] pw,
    input  logic [POS_W-1:0] ph,
    input  logic [POS_W-1:0] hx,
    input  logic [POS_W-1:0] hy,
    input  logic [POS_W-1:0] hw,
    input  logic [POS_W-1:0] hh,
    output logic             hit
);
    localparam logic [POS_W:0] S  = (POS_W+1)'(SHRINK);
    localparam logic [POS_W:0] S2 = (POS_W+1)'(2 * SHRINK);

    logic [POS_W:0] px0, px1, py0, py1, hx1, hy1;
    logic           size_ok;

    // One extra bit keeps every sum exact; a too-small box is gated out
    // before its (possibly underflowed) far edge can matter.
    always_comb begin
        px0     = {1'b0, px} + S;
        py0     = {1'b0, py} + S;
        px1     = {1'b0, px} + {1'b0, pw} - S;
        py1     = {1'b0, py} + {1'b0, ph} - S;
        hx1     = {1'b0, hx} + {1'b0, hw};
        hy1     = {1'b0, hy} + {1'b0, hh};
        size_ok = ({1'b0, pw} > S2) && ({1'b0, ph} > S2);
        hit     = size_ok && (px0 < hx1) && ({1'b0, hx} < px1)
                          && (py0 < hy1) && ({1'b0, hy} < py1);
    end
endmodule

// File: rtl/player_hit_controller.sv
// Per-frame worst-hit capture, HP update at frame_tick, invulnerability with blink.
module player_hit_controller
    import player_pkg::*;
#(
    parameter int MAX_HP        = 20,
    parameter int INVULN_FRAMES = 60,
    parameter int BLINK_FRAMES  = 4,
    parameter int HITBOX_SHRINK = 2
) (
    input  logic                     clk_player_control,
    input  logic                     reset,
    input  logic                     game_active,
    input  logic                     frame_tick,
    input  logic [POS_W-1:0]         player_pos_x,
    input  logic [POS_W-1:0]         player_pos_y,
    input  logic [POS_W-1:0]         player_w,
    input  logic [POS_W-1:0]         player_h,
    player_hit_controller_if.slave   hazard_bus,
    output logic [HP_W-1:0]          player_hp,
    output logic                     player_hit,
    output logic                     player_invulnerable,
    output logic                     player_visible,
    output logic                     player_dead,
    output player_state_t            state_dbg
);
    localparam logic [HP_W-1:0]       MAX_HP_V = HP_W'(MAX_HP);
    localparam logic signed [9:0]     MAX_HP_S = 10'(MAX_HP);
    localparam logic [7:0]            INV_V    = 8'(INVULN_FRAMES);
    localparam logic [7:0]            BLINK_V  = 8'(BLINK_FRAMES);

    player_state_t     state, state_nxt;
    logic [HP_W-1:0]   hp_q, hp_nxt;
    logic [DMG_W-1:0]  pend_dmg_q, pend_dmg_nxt;
    logic [HP_W-1:0]   pend_heal_q, pend_heal_nxt;
    logic [7:0]        inv_cnt, inv_nxt;
    logic [7:0]        blink_cnt, blink_nxt;
    logic              hit_q, hit_nxt;
    logic              vis_q, vis_nxt;

    logic              overlap;
    logic              take_hazard, take_heal;
    logic [DMG_W-1:0]  beat_dmg;
    logic [HP_W-1:0]   beat_heal;
    logic signed [9:0] hp_calc;
    logic [HP_W-1:0]   new_hp;

    player_hitbox_overlap #(.SHRINK(HITBOX_SHRINK)) u_overlap (
        .px  (player_pos_x),
        .py  (player_pos_y),
        .pw  (player_w),
        .ph  (player_h),
        .hx  (hazard_bus.hazard_x),
        .hy  (hazard_bus.hazard_y),
        .hw  (hazard_bus.hazard_w),
        .hh  (hazard_bus.hazard_h),
        .hit (overlap)
    );

    always_ff @(posedge clk_player_control) begin
        if (reset) begin
            state       <= ST_ALIVE;
            hp_q        <= MAX_HP_V;
            pend_dmg_q  <= '0;
            pend_heal_q <= '0;
            inv_cnt     <= '0;
            blink_cnt   <= '0;
            hit_q       <= 1'b0;
            vis_q       <= 1'b1;
        end else begin
            state       <= state_nxt;
            hp_q        <= hp_nxt;
            pend_dmg_q  <= pend_dmg_nxt;
            pend_heal_q <= pend_heal_nxt;
            inv_cnt     <= inv_nxt;
            blink_cnt   <= blink_nxt;
            hit_q       <= hit_nxt;
            vis_q       <= vis_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        hp_nxt        = hp_q;
        pend_dmg_nxt  = pend_dmg_q;
        pend_heal_nxt = pend_heal_q;
        inv_nxt       = inv_cnt;
        blink_nxt     = blink_cnt;
        hit_nxt       = 1'b0;
        vis_nxt       = vis_q;

        take_hazard = hazard_bus.hazard_valid && overlap && (state == ST_ALIVE);
        take_heal   = hazard_bus.heal_valid && (state != ST_DEAD);
        beat_dmg    = take_hazard ? hazard_bus.hazard_damage : '0;
        beat_heal   = take_heal ? HP_W'(hazard_bus.heal_amount) : '0;

        hp_calc = $signed({2'b00, hp_q}) + $signed({2'b00, pend_heal_q})
                - $signed({6'b000000, pend_dmg_q});
        if (hp_calc < 10'sd0)
            new_hp = '0;
        else if (hp_calc > MAX_HP_S)
            new_hp = MAX_HP_V;
        else
            new_hp = hp_calc[HP_W-1:0];

        if (game_active && state != ST_DEAD) begin
            if (frame_tick) begin
                // Beats coincident with the tick seed the next frame's pending values.
                hp_nxt        = new_hp;
                pend_dmg_nxt  = '0;
                pend_heal_nxt = sat_add_hp('0, beat_heal, MAX_HP_V);
                case (state)
                    ST_ALIVE: begin
                        if (pend_dmg_q != '0) begin
                            hit_nxt = 1'b1;
                            if (new_hp == '0) begin
                                state_nxt = ST_DEAD;
                            end else begin
                                state_nxt = ST_INVULN;
                                inv_nxt   = INV_V;
                                blink_nxt = '0;
                            end
                        end else begin
                            pend_dmg_nxt = beat_dmg;
                        end
                    end
                    ST_INVULN: begin
                        inv_nxt = inv_cnt - 8'd1;
                        if (inv_cnt == 8'd1) begin
                            state_nxt = ST_ALIVE;
                            vis_nxt   = 1'b1;
                            blink_nxt = '0;
                        end else if (blink_cnt == BLINK_V - 8'd1) begin
                            blink_nxt = '0;
                            vis_nxt   = ~vis_q;
                        end else begin
                            blink_nxt = blink_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end else begin
                pend_dmg_nxt  = (beat_dmg > pend_dmg_q) ? beat_dmg : pend_dmg_q;
                pend_heal_nxt = sat_add_hp(pend_heal_q, beat_heal, MAX_HP_V);
            end
        end
    end

    assign player_hp           = hp_q;
    assign player_hit          = hit_q;
    assign player_invulnerable = (state == ST_INVULN);
    assign player_visible      = vis_q;
    assign player_dead         = (state == ST_DEAD);
    assign state_dbg           = state;
endmodule

// File: tb/tb_player_hit_controller.sv
// Scoreboard bench: each tick/reset pushes an expected output snapshot; a monitor compares.
module tb_player_hit_controller;
    import player_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic game_active = 1'b1;
    logic frame_tick = 1'b0;
    logic [9:0] player_pos_x = 10'd320;
    logic [9:0] player_pos_y = 10'd240;
    logic [9:0] player_w = 10'd30;
    logic [9:0] player_h = 10'd30;
    logic [7:0] player_hp;
    logic player_hit, player_invulnerable, player_visible, player_dead;
    player_state_t state_dbg;

    player_hit_controller_if hb();

    player_hit_controller dut (
        .clk_player_control  (clk),
        .reset               (reset),
        .game_active         (game_active),
        .frame_tick          (frame_tick),
        .player_pos_x        (player_pos_x),
        .player_pos_y        (player_pos_y),
        .player_w            (player_w),
        .player_h            (player_h),
        .hazard_bus          (hb),
        .player_hp           (player_hp),
        .player_hit          (player_hit),
        .player_invulnerable (player_invulnerable),
        .player_visible      (player_visible),
        .player_dead         (player_dead),
        .state_dbg           (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic tick_d = 1'b0;
    logic rst_d = 1'b0;
    always @(posedge clk) begin
        tick_d <= frame_tick;
        rst_d  <= reset;
    end

    // scoreboard: {hp[7:0], hit, invulnerable, visible, dead}
    logic [11:0] exp_q[$];
    string       name_q[$];
    int tests = 0;
    int fails = 0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    function automatic logic [11:0] snap(input int hp, input bit hit, input bit inv,
                                         input bit vis, input bit dead);
        return {8'(hp), hit, inv, vis, dead};
    endfunction

    always @(negedge clk) begin
        logic [11:0] got, exp;
        string nm;
        got = {player_hp, player_hit, player_invulnerable, player_visible, player_dead};
        if (player_hit && !tick_d) begin
            tests++;
            fails++;
            $display("FAIL stray_hit: player_hit=1 in a cycle not following a tick, required 0");
        end
        if (tick_d || rst_d) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL no_expectation: got %h with empty queue", got);
            end else begin
                exp = exp_q.pop_front();
                nm  = name_q.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL %s: got hp=%0d hit=%b inv=%b vis=%b dead=%b, required hp=%0d hit=%b inv=%b vis=%b dead=%b",
                             nm, got[11:4], got[3], got[2], got[1], got[0],
                             exp[11:4], exp[3], exp[2], exp[1], exp[0]);
                end
            end
        end
        if (end_req && !end_ack) begin
            tests++;
            if (exp_q.size() != 0) begin
                fails++;
                $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
            end
            end_ack <= 1'b1;
        end
    end

    // driver tasks; each starts and ends 1 time unit after a rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hazard(input int x, input int y, input int w, input int h, input int d);
        hb.hazard_valid  = 1'b1;
        hb.hazard_x      = 10'(x);
        hb.hazard_y      = 10'(y);
        hb.hazard_w      = 10'(w);
        hb.hazard_h      = 10'(h);
        hb.hazard_damage = 4'(d);
        step();
        hb.hazard_valid  = 1'b0;
    endtask

    task automatic heal(input int a);
        hb.heal_valid  = 1'b1;
        hb.heal_amount = 4'(a);
        step();
        hb.heal_valid  = 1'b0;
    endtask

    task automatic tick(input string nm, input logic [11:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        exp_q.push_back(snap(20, 0, 0, 1, 0));
        name_q.push_back(nm);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // 60 invulnerable ticks: visible drops every 4th tick, tick 60 is ALIVE again
    task automatic run_invuln(input int hp, input bit with_hz);
        for (int i = 1; i <= 60; i++) begin
            if (with_hz) hazard(340, 250, 10, 10, 9);
            if (i == 60) tick("invuln_exit", snap(hp, 0, 0, 1, 0));
            else         tick("invuln_tick", snap(hp, 0, 1, ((i / 4) % 2) == 0, 0));
        end
    endtask

    initial begin
        hb.hazard_valid  = 1'b0;
        hb.hazard_x      = '0;
        hb.hazard_y      = '0;
        hb.hazard_w      = '0;
        hb.hazard_h      = '0;
        hb.hazard_damage = '0;
        hb.heal_valid    = 1'b0;
        hb.heal_amount   = '0;
        exp_q.push_back(snap(20, 0, 0, 1, 0));
        name_q.push_back("reset_state");
        step();
        reset = 1'b0;
        step();

        hazard(340, 250, 10, 10, 3);
        tick("first_hit", snap(17, 1, 1, 1, 0));
        for (int i = 1; i <= 4; i++) tick("blink_early", snap(17, 0, 1, i < 4, 0));
        do_reset("reset_mid_invuln");

        hazard(348, 250, 10, 10, 3);
        tick("edge_right_touch", snap(20, 0, 0, 1, 0));
        hazard(312, 250, 10, 10, 3);
        tick("edge_left_touch", snap(20, 0, 0, 1, 0));
        hazard(340, 268, 10, 10, 3);
        tick("edge_bottom_touch", snap(20, 0, 0, 1, 0));
        player_w = 10'd4;
        hazard(320, 240, 30, 30, 3);
        tick("tiny_player", snap(20, 0, 0, 1, 0));
        player_w = 10'd30;
        hazard(347, 250, 10, 10, 3);
        tick("edge_inside", snap(17, 1, 1, 1, 0));
        do_reset("reset_again");

        hazard(340, 250, 10, 10, 3);
        hazard(330, 245, 5, 5, 5);
        tick("max_not_sum", snap(15, 1, 1, 1, 0));
        run_invuln(15, 1'b1);

        hazard(340, 250, 10, 10, 11);
        tick("dmg11", snap(4, 1, 1, 1, 0));
        run_invuln(4, 1'b0);
        heal(3);
        hazard(340, 250, 10, 10, 5);
        tick("heal_and_dmg", snap(2, 1, 1, 1, 0));
        run_invuln(2, 1'b0);
        heal(15);
        tick("heal15", snap(17, 0, 0, 1, 0));
        heal(2);
        tick("heal2", snap(19, 0, 0, 1, 0));
        heal(5);
        tick("heal_cap", snap(20, 0, 0, 1, 0));

        hb.hazard_valid  = 1'b1;
        hb.hazard_x      = 10'd340;
        hb.hazard_y      = 10'd250;
        hb.hazard_w      = 10'd10;
        hb.hazard_h      = 10'd10;
        hb.hazard_damage = 4'd2;
        tick("coincident_tick", snap(20, 0, 0, 1, 0));
        hb.hazard_valid  = 1'b0;
        tick("coincident_next", snap(18, 1, 1, 1, 0));
        run_invuln(18, 1'b0);

        game_active = 1'b0;
        hazard(340, 250, 10, 10, 3);
        heal(1);
        tick("frozen_tick", snap(18, 0, 0, 1, 0));
        game_active = 1'b1;
        tick("after_freeze", snap(18, 0, 0, 1, 0));
        hazard(340, 250, 10, 10, 1);
        game_active = 1'b0;
        tick("frozen_pending", snap(18, 0, 0, 1, 0));
        game_active = 1'b1;
        tick("pending_held", snap(17, 1, 1, 1, 0));
        run_invuln(17, 1'b0);

        hazard(340, 250, 10, 10, 14);
        tick("dmg14", snap(3, 1, 1, 1, 0));
        run_invuln(3, 1'b0);
        hazard(340, 250, 10, 10, 7);
        tick("death", snap(0, 1, 0, 1, 1));
        heal(5);
        tick("dead_heal", snap(0, 0, 0, 1, 1));
        hazard(340, 250, 10, 10, 3);
        tick("dead_hazard", snap(0, 0, 0, 1, 1));
        do_reset("reset_from_dead");
        tick("alive_after_reset", snap(20, 0, 0, 1, 0));

        step();
        step();
        end_req = 1'b1;
        for (int i = 0; i < 5 && !end_ack; i++) step();
        if (!end_ack) begin
            $display("FAIL end_handshake: monitor did not acknowledge");
            $fatal(1, "monitor stalled");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
